// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - rv32i fetch program counter with stall, redirect, trap and debug halt (optional PC_ALIGN_CHK_EN)
//
// Holds the fetch PC and offers it to instruction memory with a valid/ready
// handshake. A BOOT cycle follows reset, then RUN fetches until a debug halt.
// Trap and redirect rewrite the PC in any state except BOOT, so they act as a
// pipeline flush while stalled and as a debugger PC write while halted.
//
// Build option: define PC_ALIGN_CHK_EN to turn a misaligned redirect into a
// fault that vectors to trap_base and pulses misaligned for one cycle.
// Without it the low two bits of the redirect target are simply dropped.

module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INC          = 4,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  pc_out,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_base,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misaligned
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [XLEN-1:0]  INC_X   = XLEN'(INC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             halted_q, halted_d;
  logic             misaligned_q, misaligned_d;

  logic             accept;
  logic             redirect_fault;
  logic [XLEN-1:0]  trap_target;
  logic [XLEN-1:0]  redirect_target;

  // Instruction addresses are word aligned, so the low two bits of every
  // incoming target are forced to zero; these bits are otherwise unread.
  logic unused_low_bits;
  assign unused_low_bits = ^{trap_base[1:0], redirect_pc[1:0]};

  assign trap_target     = {trap_base[XLEN-1:2], 2'b00};
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef PC_ALIGN_CHK_EN
  // A redirect to a non word-aligned address is a fault taken through mtvec.
  assign redirect_fault = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  // Alignment is not checked; the target is silently rounded down.
  assign redirect_fault = 1'b0;
`endif

  // Fetch request is offered only while running and not stalled.
  always_comb begin
    fetch_valid = (state_q == RUN) && !stall;
    accept      = fetch_valid && fetch_ready;
  end

  // Next-state logic: leave BOOT after one cycle, halt/resume under debug control.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        // A resume that arrives with halt_req still high is ignored.
        if (resume && !halt_req) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC selection: trap over redirect over sequential advance; BOOT holds the reset vector.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = 1'b0;
    if (state_q != BOOT) begin
      if (trap_valid) begin
        pc_d = trap_target;
      end else if (redirect_valid) begin
        if (redirect_fault) begin
          pc_d         = trap_target;
          misaligned_d = 1'b1;
        end else begin
          pc_d = redirect_target;
        end
      end else if (accept) begin
        pc_d = pc_q + INC_X;
      end
    end
  end

  // Fetch counter and halted flag; an accepted fetch counts even if flushed.
  always_comb begin
    count_d  = accept ? (count_q + CNT_ONE) : count_q;
    halted_d = (state_d == HALT);
  end

  // State register with asynchronous reset so a reset takes effect between edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      count_q      <= '0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc_out      = pc_q;
  assign fetch_count = count_q;
  assign halted      = halted_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit (honours PC_ALIGN_CHK_EN)

module tb_pc_unit;

`ifdef PC_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_base;
  logic        halt_req;
  logic        resume;
  logic        halted;
  logic [15:0] fetch_count;
  logic        misaligned;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: architectural view of the unit.
  logic [31:0] m_pc;
  logic [15:0] m_count;
  bit          m_boot;
  bit          m_halt;
  bit          m_mis;

  pc_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .fetch_ready    (fetch_ready),
    .fetch_valid    (fetch_valid),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_base      (trap_base),
    .halt_req       (halt_req),
    .resume         (resume),
    .halted         (halted),
    .fetch_count    (fetch_count),
    .misaligned     (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic set_idle();
    stall          = 1'b0;
    fetch_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    trap_base      = '0;
    halt_req       = 1'b0;
    resume         = 1'b0;
  endtask

  // Applies the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    bit acc;
    acc   = !m_boot && !m_halt && !stall && fetch_ready;
    m_mis = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else begin
      if (trap_valid) begin
        m_pc = (trap_base / 4) * 4;
      end else if (redirect_valid) begin
        if (ALIGN_CHK && (redirect_pc % 4 != 0)) begin
          m_pc  = (trap_base / 4) * 4;
          m_mis = 1'b1;
        end else begin
          m_pc = (redirect_pc / 4) * 4;
        end
      end else if (acc) begin
        m_pc = m_pc + 32'd4;
      end
      if (acc) m_count = m_count + 16'd1;
      if (!m_halt && halt_req) m_halt = 1'b1;
      else if (m_halt && resume && !halt_req) m_halt = 1'b0;
    end
  endtask

  // One clock: update the model from the inputs, then step just past the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    m_pc = 32'h0; m_count = '0; m_boot = 1'b1; m_halt = 1'b0; m_mis = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    fetch_ready = 1'b1;
    #1;
    tests_run++;
    if (pc_out !== 32'h0 || halted !== 1'b0 || fetch_count !== 16'd0 || misaligned !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state pc=%h halted=%b cnt=%0d mis=%b expected pc=0 halted=0 cnt=0 mis=0",
               pc_out, halted, fetch_count, misaligned);
    end
    tests_run++;
    if (fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot_valid got %b expected 0", fetch_valid);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (fetch_valid !== 1'b1 || pc_out !== 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL t1_seq%0d pc=%h valid=%b expected pc=%h valid=1", i, pc_out, fetch_valid, 4 * i);
      end
      tick();
    end
    tests_run++;
    if (fetch_count !== 16'd3 || pc_out !== 32'hC) begin
      tests_failed++;
      $display("FAIL t1_count cnt=%0d pc=%h expected cnt=3 pc=0000000c", fetch_count, pc_out);
    end
  endtask

  task automatic test_stall_redirect();
    logic [15:0] cnt0;
    set_idle();
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b1;
    cnt0           = 16'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (pc_out !== 32'h8 || fetch_valid !== 1'b0 || fetch_count !== cnt0) begin
        tests_failed++;
        $display("FAIL t2_stall%0d pc=%h valid=%b cnt=%0d expected pc=00000008 valid=0 cnt=%0d",
                 i, pc_out, fetch_valid, fetch_count, cnt0);
      end
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    tests_run++;
    if (pc_out !== 32'h40 || fetch_count !== cnt0) begin
      tests_failed++;
      $display("FAIL t2_stall_redirect pc=%h cnt=%0d expected pc=00000040 cnt=%0d", pc_out, fetch_count, cnt0);
    end
  endtask

  task automatic test_trap_priority();
    logic [15:0] cnt0;
    set_idle();
    cnt0 = fetch_count;
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    trap_valid     = 1'b1;
    trap_base      = 32'h203;
    tick();
    tests_run++;
    if (pc_out !== 32'h200 || fetch_count !== cnt0 + 16'd1) begin
      tests_failed++;
      $display("FAIL t3_trap_wins pc=%h cnt=%0d expected pc=00000200 cnt=%0d", pc_out, fetch_count, cnt0 + 16'd1);
    end
  endtask

  task automatic test_halt();
    set_idle();
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    halt_req       = 1'b1;
    tick();
    halt_req = 1'b0;
    #1;
    tests_run++;
    if (pc_out !== 32'h14 || halted !== 1'b1 || fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_halt pc=%h halted=%b valid=%b expected pc=00000014 halted=1 valid=0",
               pc_out, halted, fetch_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (pc_out !== 32'h80 || halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_halt_write pc=%h halted=%b expected pc=00000080 halted=1", pc_out, halted);
    end
    resume   = 1'b1;
    halt_req = 1'b1;
    tick();
    tests_run++;
    if (halted !== 1'b1) begin
      tests_failed++;
      $display("FAIL t4_resume_blocked halted=%b expected 1", halted);
    end
    halt_req = 1'b0;
    tick();
    resume = 1'b0;
    #1;
    tests_run++;
    if (halted !== 1'b0 || fetch_valid !== 1'b1 || pc_out !== 32'h80) begin
      tests_failed++;
      $display("FAIL t4_resume halted=%b valid=%b pc=%h expected halted=0 valid=1 pc=00000080",
               halted, fetch_valid, pc_out);
    end
    tick();
    tests_run++;
    if (pc_out !== 32'h84) begin
      tests_failed++;
      $display("FAIL t4_fetch_after_resume pc=%h expected 00000084", pc_out);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] exp_pc;
    logic        exp_mis;
    set_idle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    trap_base      = 32'h300;
    exp_pc         = ALIGN_CHK ? 32'h300 : 32'h100;
    exp_mis        = ALIGN_CHK;
    tick();
    set_idle();
    tests_run++;
    if (pc_out !== exp_pc || misaligned !== exp_mis) begin
      tests_failed++;
      $display("FAIL t5_misaligned pc=%h mis=%b expected pc=%h mis=%b", pc_out, misaligned, exp_pc, exp_mis);
    end
    tick();
    tests_run++;
    if (misaligned !== 1'b0 || pc_out !== exp_pc) begin
      tests_failed++;
      $display("FAIL t5_pulse_end mis=%b pc=%h expected mis=0 pc=%h", misaligned, pc_out, exp_pc);
    end
  endtask

  task automatic test_wrap_async_reset();
    set_idle();
    fetch_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (pc_out !== 32'hFFFF_FFFC) begin
      tests_failed++;
      $display("FAIL t6_top pc=%h expected fffffffc", pc_out);
    end
    tick();
    tests_run++;
    if (pc_out !== 32'h0) begin
      tests_failed++;
      $display("FAIL t6_wrap pc=%h expected 00000000", pc_out);
    end
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (pc_out !== 32'h0 || fetch_count !== 16'd0 || halted !== 1'b0 || fetch_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL t6_async_reset pc=%h cnt=%0d halted=%b valid=%b expected pc=0 cnt=0 halted=0 valid=0",
               pc_out, fetch_count, halted, fetch_valid);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit exp_valid;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      stall          = ($urandom_range(0, 3) == 0);
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = $urandom;
      trap_valid     = ($urandom_range(0, 15) == 0);
      trap_base      = $urandom;
      halt_req       = ($urandom_range(0, 15) == 0);
      resume         = ($urandom_range(0, 3) == 0);
      #1;
      exp_valid = !m_boot && !m_halt && !stall;
      tests_run++;
      if (fetch_valid !== exp_valid) begin
        tests_failed++;
        $display("FAIL rnd_valid cycle %0d got %b expected %b", n, fetch_valid, exp_valid);
      end
      tick();
      tests_run++;
      if (pc_out !== m_pc || fetch_count !== m_count || halted !== m_halt || misaligned !== m_mis) begin
        tests_failed++;
        $display("FAIL rnd_state cycle %0d pc=%h cnt=%0d halted=%b mis=%b expected pc=%h cnt=%0d halted=%b mis=%b",
                 n, pc_out, fetch_count, halted, misaligned, m_pc, m_count, m_halt, m_mis);
      end
    end
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    test_reset();
    test_stall_redirect();
    test_trap_priority();
    test_halt();
    test_misaligned();
    test_wrap_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
